mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single memory port between the CPU's instruction-fetch and data (load/store) requesters. It arbitrates between them, sequences one memory transaction at a time, and returns read data. It also produces the stall and fault indications that the control FSM consumes: `wait_instr`, `wait_data`, `instr_segv` and `data_segv`. Address faults and memory timeouts are reported as segv and never reach, or never hang, the CPU.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: word width.
- `MEM_BYTES`, default 65536: size of the legal address space; an address ≥ `MEM_BYTES` faults.
- `TIMEOUT`, default 15: maximum cycles to wait for `m_ack` before faulting. Must be ≥ 1.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset: asynchronous, active-high.
- `i_req`  in  1  instruction fetch request; level, held until `i_ready`.
- `i_addr`  in  `ADDR_W`  fetch address.
- `i_rdata`  out  `DATA_W`  fetched word; valid while `i_ready`.
- `i_ready`  out  1  one-cycle completion pulse.
- `instr_segv`  out  1  fault flag; valid with `i_ready`.
- `wait_instr`  out  1  equals `i_req & ~i_ready`.
- `d_req`  in  1  data request; level, held until `d_ready`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  `ADDR_W`  data address.
- `d_wdata`  in  `DATA_W`  store data.
- `d_rdata`  out  `DATA_W`  load data; valid while `d_ready`.
- `d_ready`  out  1  one-cycle completion pulse.
- `data_segv`  out  1  fault flag; valid with `d_ready`.
- `wait_data`  out  1  equals `d_req & ~d_ready`.
- `m_req`  out  1  memory request; held until `m_ack`.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  `ADDR_W`  memory address.
- `m_wdata`  out  `DATA_W`  memory write data.
- `m_rdata`  in  `DATA_W`  memory read data; valid with `m_ack`.
- `m_ack`  in  1  memory completion; one-cycle pulse.

## Operation
- Four states:
  - `IDLE`: no transaction in flight.
  - `I_BUSY`: fetch transaction outstanding.
  - `D_BUSY`: data transaction outstanding.
  - `RESP`: completion cycle.
- Only one transaction is outstanding at a time.
- Arbitration happens in `IDLE` when at least one request is high.
  - If only one requester is high, it wins.
  - If both are high, round-robin: the requester not served last wins.
  - The `last` bit resets to instr-served, so data wins the first tie.
- Fault check happens at grant time:
  - The fault condition is `addr ≥ MEM_BYTES` or `addr[1:0] != 0`.
  - On a fault there is no memory access. Go directly to `RESP` with the requester's segv flag set and rdata = 0.
- On a legal grant:
  - Register `m_addr`, `m_we`, `m_wdata` from the winner and assert `m_req`.
  - For fetches, `m_we` = 0.
  - Enter `I_BUSY` or `D_BUSY` and load the timeout counter with `TIMEOUT`.
- In a BUSY state:
  - On `m_ack`: capture `m_rdata` into the winner's rdata register (0 for stores), deassert `m_req`, and go to `RESP`.
  - Otherwise decrement the counter. When it reaches 0 without an ack, deassert `m_req`, set segv, set rdata = 0, and go to `RESP`.
  - An `m_ack` in the same cycle the counter reaches 0 counts as success.
- `RESP`:
  - Pulse the winner's ready for exactly one cycle, update `last`, and return to `IDLE`.
  - Segv flags and rdata hold their values until the next `RESP` for that port.
- The requester drops or changes its request in the cycle after ready. A request seen in `IDLE` is always treated as new.
- `m_ack` outside BUSY states is ignored.
- Request inputs that change mid-transaction are ignored; the captured values are used.
- Reset (asynchronous, any state):
  - state = `IDLE`, `last` = instr, counter = 0.
  - `m_req`, `m_we`, `i_ready`, `d_ready`, `instr_segv`, `data_segv` = 0.
  - `m_addr`, `m_wdata`, `i_rdata`, `d_rdata` = 0.
  - An in-flight memory access is abandoned; a stale `m_ack` after reset is ignored.

## Timing
- All outputs are registered, except `wait_instr` and `wait_data`, which are combinational.
- Legal access: request seen in cycle 0 (`IDLE`) → `m_req` high from cycle 1 → `m_ack` in cycle k ≥ 1 → ready high in cycle k+1.
  - Minimum latency is 2 cycles, with ack in cycle 1.
- Faulting address: ready plus segv in cycle 1.
- Timeout: `m_req` high for cycles 1..`TIMEOUT`+1, then ready plus segv in cycle `TIMEOUT`+2.
- Throughput: back-to-back accesses need at least 3 cycles each (`IDLE`, BUSY, `RESP`).

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (`IDLE`, `I_BUSY`, `D_BUSY`, `RESP`);
  - the requester id constants (`REQ_I`, `REQ_D`);
  - the fault-check function `addr_fault(addr)`.
- Sub-module `mem_arb_timer`: a loadable down-counter with load, decrement and expired outputs, sized `$clog2(TIMEOUT+1)`.

## Test plan
- Fetch only: `i_addr` = 0x100; memory acks in cycle 1 with 0xDEADBEEF → `i_ready` in cycle 2, `i_rdata` = 0xDEADBEEF, `instr_segv` = 0, `wait_instr` high in cycles 0–1.
- Simultaneous requests after reset: first grant goes to data. When both re-request, instr is granted next, and the two alternate thereafter.
- Store: `d_addr` = 0x20, `d_wdata` = 0x12345678 → `m_we` = 1, `m_addr` = 0x20, `m_wdata` = 0x12345678; after ack, `d_ready` = 1 and `d_rdata` = 0.
- Faults:
  - `d_addr` = `MEM_BYTES` → `d_ready` plus `data_segv` in cycle 1, `m_req` never asserted.
  - `i_addr` = 0x102 → `instr_segv` set.
- Timeout: memory never acks, `TIMEOUT` = 15 → `m_req` high for 16 cycles, then `i_ready` plus `instr_segv` in cycle 17; a subsequent legal request completes normally.
- Reset mid-transaction: assert `reset_n` during `D_BUSY`; ack arrives after reset releases → all outputs 0, the ack is ignored, state = `IDLE`.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types, requester ids and address fault check for the
//               instruction/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Out-of-range or not word aligned; the caller widens both operands.
    function automatic logic addr_fault(input logic [63:0] addr, input logic [63:0] limit);
        return (addr >= limit) || (addr[1:0] != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_timer
// Description : Loadable down-counter bounding the wait for a memory ack.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_timer #(
    parameter int TIMEOUT = 15,
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
)(
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(TIMEOUT);
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one memory port between fetch and
//               load/store requesters, with address fault and timeout segv.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 65536,
    parameter int TIMEOUT   = 15
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              instr_segv,
    output logic              wait_instr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              data_segv,
    output logic              wait_data,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);

    arb_state_t        state, state_next;
    logic              last, last_next;
    logic              owner, owner_next;
    logic              m_req_next, m_we_next;
    logic [ADDR_W-1:0] m_addr_next;
    logic [DATA_W-1:0] m_wdata_next;
    logic [DATA_W-1:0] i_rdata_next, d_rdata_next;
    logic              i_ready_next, d_ready_next;
    logic              instr_segv_next, data_segv_next;

    logic              tmr_load, tmr_dec, tmr_expired;
    logic              grant_d, grant_fault;
    logic [ADDR_W-1:0] grant_addr;

    logic              done;
    logic              done_port;
    logic              done_segv;
    logic [DATA_W-1:0] done_rdata;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .dec     (tmr_dec),
        .expired (tmr_expired)
    );

    // On a tie the requester not served last wins.
    assign grant_d     = d_req & (~i_req | (last == REQ_I));
    assign grant_addr  = grant_d ? d_addr : i_addr;
    assign grant_fault = addr_fault(64'(grant_addr), 64'(MEM_BYTES));

    assign wait_instr  = i_req & ~i_ready;
    assign wait_data   = d_req & ~d_ready;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state      <= IDLE;
            last       <= REQ_I;
            owner      <= REQ_I;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            instr_segv <= 1'b0;
            data_segv  <= 1'b0;
        end else begin
            state      <= state_next;
            last       <= last_next;
            owner      <= owner_next;
            m_req      <= m_req_next;
            m_we       <= m_we_next;
            m_addr     <= m_addr_next;
            m_wdata    <= m_wdata_next;
            i_rdata    <= i_rdata_next;
            d_rdata    <= d_rdata_next;
            i_ready    <= i_ready_next;
            d_ready    <= d_ready_next;
            instr_segv <= instr_segv_next;
            data_segv  <= data_segv_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_next       = last;
        owner_next      = owner;
        m_req_next      = m_req;
        m_we_next       = m_we;
        m_addr_next     = m_addr;
        m_wdata_next    = m_wdata;
        i_rdata_next    = i_rdata;
        d_rdata_next    = d_rdata;
        i_ready_next    = 1'b0;
        d_ready_next    = 1'b0;
        instr_segv_next = instr_segv;
        data_segv_next  = data_segv;
        tmr_load        = 1'b0;
        tmr_dec         = 1'b0;
        done            = 1'b0;
        done_port       = owner;
        done_segv       = 1'b0;
        done_rdata      = '0;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_next = grant_d ? REQ_D : REQ_I;
                    if (grant_fault) begin
                        done       = 1'b1;
                        done_port  = grant_d ? REQ_D : REQ_I;
                        done_segv  = 1'b1;
                        state_next = RESP;
                    end else begin
                        m_req_next   = 1'b1;
                        m_we_next    = grant_d & d_we;
                        m_addr_next  = grant_addr;
                        m_wdata_next = grant_d ? d_wdata : '0;
                        tmr_load     = 1'b1;
                        state_next   = grant_d ? D_BUSY : I_BUSY;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                // An ack in the same cycle as expiry wins over the timeout.
                if (m_ack) begin
                    m_req_next = 1'b0;
                    done       = 1'b1;
                    done_rdata = m_we ? '0 : m_rdata;
                    state_next = RESP;
                end else if (tmr_expired) begin
                    m_req_next = 1'b0;
                    done       = 1'b1;
                    done_segv  = 1'b1;
                    state_next = RESP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            RESP: begin
                last_next  = owner;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (done) begin
            if (done_port == REQ_D) begin
                d_ready_next   = 1'b1;
                d_rdata_next   = done_rdata;
                data_segv_next = done_segv;
            end else begin
                i_ready_next    = 1'b1;
                i_rdata_next    = done_rdata;
                instr_segv_next = done_segv;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter with a simple memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_BYTES = 65536;
    localparam int TIMEOUT   = 15;
    localparam bit PI        = 1'b0;
    localparam bit PD        = 1'b1;

    typedef struct packed {
        bit          port;
        logic [31:0] rdata;
        bit          segv;
    } resp_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_req, d_req, d_we;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] i_rdata, d_rdata;
    logic              i_ready, d_ready, instr_segv, data_segv;
    logic              wait_instr, wait_data;
    logic              m_req, m_we, m_ack;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;

    logic              mem_ack, force_ack;
    bit                mem_en, mem_fixed_en;
    int                mem_delay;
    logic [31:0]       mem_fixed;

    int                errors = 0;
    int                checks = 0;
    resp_t             exp_q[$];

    assign m_ack = mem_ack | force_ack;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_BYTES (MEM_BYTES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .instr_segv (instr_segv),
        .wait_instr (wait_instr),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .data_segv  (data_segv),
        .wait_data  (wait_data),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ack      (m_ack)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, {m_req, m_we, i_ready, d_ready, instr_segv, data_segv}, 0);
        chk({name, "_maddr"}, m_addr, 0);
        chk({name, "_mwdata"}, m_wdata, 0);
        chk({name, "_irdata"}, i_rdata, 0);
        chk({name, "_drdata"}, d_rdata, 0);
    endtask

    // Memory model: acks mem_delay cycles after m_req is first seen.
    initial begin
        int wcnt;
        wcnt    = 0;
        mem_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (m_req && mem_en) begin
                if (wcnt == mem_delay) begin
                    mem_ack = 1'b1;
                    m_rdata = mem_fixed_en ? mem_fixed : mem_word(m_addr);
                    wcnt    = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: every ready pulse is matched against the scoreboard head.
    initial begin
        resp_t exp;
        forever begin
            @(negedge clk);
            if (i_ready || d_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", {i_ready, d_ready}, 0);
                end else begin
                    exp = exp_q.pop_front();
                    if (i_ready)
                        chk("resp_port_rdata_segv", {1'b0, i_rdata, instr_segv}, exp);
                    if (d_ready)
                        chk("resp_port_rdata_segv", {1'b1, d_rdata, data_segv}, exp);
                end
            end
        end
    end

    task automatic xact(input bit port, input logic [31:0] addr, input bit we,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input bit exp_segv, input int exp_lat, input int exp_mreq);
        int lat, mreq;
        bit seen, done;
        @(negedge clk);
        exp_q.push_back('{port: port, rdata: exp_rdata, segv: exp_segv});
        if (port == PI) begin
            i_req  = 1'b1;
            i_addr = addr;
        end else begin
            d_req   = 1'b1;
            d_we    = we;
            d_addr  = addr;
            d_wdata = wdata;
        end
        #1;
        chk("wait_c0", port ? wait_data : wait_instr, 1);
        lat = 0; mreq = 0; seen = 0; done = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (m_req) begin
                mreq++;
                if (!seen) begin
                    seen = 1;
                    chk("m_addr", m_addr, addr);
                    chk("m_we", m_we, we);
                    if (we) chk("m_wdata", m_wdata, wdata);
                end
            end
            if (port ? d_ready : i_ready) begin
                done = 1;
                chk("wait_at_ready", port ? wait_data : wait_instr, 0);
            end else begin
                chk("wait_busy", port ? wait_data : wait_instr, 1);
            end
        end
        if (!done) chk("ready_timeout", 0, 1);
        chk("latency", lat, exp_lat);
        chk("m_req_cycles", mreq, exp_mreq);
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    // Both requesters held high; grants must alternate starting with first_d.
    task automatic tie(input int n, input logic [31:0] ia, input logic [31:0] da, input bit first_d);
        int got, cyc;
        bit p;
        @(negedge clk);
        p = first_d;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{port: p, rdata: mem_word(p ? da : ia), segv: 1'b0});
            p = ~p;
        end
        i_req  = 1'b1;
        i_addr = ia;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = da;
        got = 0; cyc = 0;
        while (got < n && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (i_ready || d_ready) got++;
        end
        if (got < n) chk("tie_timeout", got, n);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b1;
        i_req        = 1'b0;
        d_req        = 1'b0;
        d_we         = 1'b0;
        i_addr       = '0;
        d_addr       = '0;
        d_wdata      = '0;
        force_ack    = 1'b0;
        mem_en       = 1'b1;
        mem_fixed_en = 1'b0;
        mem_fixed    = '0;
        mem_delay    = 0;

        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        chk("reset_wait", {wait_instr, wait_data}, 0);

        tie(4, 32'h40, 32'h80, 1'b1);

        mem_fixed_en = 1'b1;
        mem_fixed    = 32'hDEADBEEF;
        xact(PI, 32'h100, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1);
        mem_fixed_en = 1'b0;

        xact(PD, 32'h20, 1'b1, 32'h12345678, 32'h0, 1'b0, 2, 1);
        xact(PD, MEM_BYTES, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0);
        xact(PI, 32'h102, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0);
        chk("data_segv_hold", data_segv, 1);

        mem_delay = 3;
        xact(PD, 32'h300, 1'b0, 32'h0, 32'hC0DE0300, 1'b0, 5, 4);
        mem_delay = TIMEOUT;
        xact(PI, 32'h104, 1'b0, 32'h0, 32'hC0DE0104, 1'b0, 17, 16);

        mem_en = 1'b0;
        xact(PI, 32'h200, 1'b0, 32'h0, 32'h0, 1'b1, 17, 16);
        mem_en    = 1'b1;
        mem_delay = 0;
        xact(PD, 32'h0, 1'b0, 32'h0, 32'hC0DE0000, 1'b0, 2, 1);
        chk("instr_segv_hold", instr_segv, 1);

        // Reset in the middle of a data transaction, then a stale ack.
        @(negedge clk);
        mem_en = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h44;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", m_req, 1);
        #2;
        reset_n = 1'b1;
        #1;
        chk_all_zero("async_reset");
        d_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("stale_ack");
        mem_en = 1'b1;

        tie(2, 32'h48, 32'h88, 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
